sd_search_ctrl: RTL
===================

Name: sd_search_ctrl

Overview:
- Depth-first tree-search controller for the 4-layer, 8-ary sphere decoder.
- Sits directly downstream of the combinational metric calculator and closes the loop around it:
  - drives the candidate symbols S_0..S_3 and current_node_lvl into the calculator;
  - samples the returned current_node_cost in the same cycle.
- Prunes each node against a shrinking radius and keeps the best leaf, i.e. the ML estimate.

Parameters:
- WIDTH, 32: cost and radius width; must match the metric calculator.
- MAX_NODES, 4680: node-evaluation budget (8+64+512+4096 = full tree).
- CNT_W, 13: node_count width; must satisfy 2^CNT_W > MAX_NODES.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; launches a search. Ignored unless in IDLE.
- init_radius  input  WIDTH  initial squared search radius, unsigned.
- current_node_cost  input  WIDTH  cost from the metric calculator, unsigned, combinational.
- S_0, S_1, S_2, S_3  output  3 each  candidate symbol indices to the calculator.
- current_node_lvl  output  2  level being evaluated; 3 = root layer.
- busy  output  1  high in EVAL and BACK.
- done  output  1  one-cycle pulse at search end.
- found  output  1  at least one leaf accepted; valid from done until next start.
- aborted  output  1  search ended because MAX_NODES was reached.
- best_S_0, best_S_1, best_S_2, best_S_3  output  3 each  best leaf symbols.
- best_cost  output  WIDTH  cost of best leaf; equals the final radius.
- node_count  output  CNT_W  EVAL cycles performed in this search.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; S_0..S_3=0; current_node_lvl=3; radius=0.
  - All best_* = 0; busy, done, found, aborted = 0; node_count=0.
- Upstream holds InData and R stable while busy=1; this block does not check that.
- Cost comparisons are unsigned. "Accept" means cost < radius, strictly.
- IDLE, on start:
  - radius <= init_radius; S_0..S_3 <= 0; lvl <= 3.
  - node_count, found and aborted cleared.
  - Next state EVAL.
- EVAL (level L, one node per cycle, node_count += 1):
  - Accept and L>0: descend. lvl <= L-1; S_(L-1) <= 0.
  - Accept and L=0: record leaf. best_S <= S; best_cost <= cost; radius <= cost; found <= 1. Then advance the sibling.
  - Reject: advance the sibling.
  - Advance sibling:
    - if S_L < 7: S_L += 1, stay in EVAL;
    - else if L=3: go to DONE;
    - else lvl <= L+1, go to BACK.
  - Budget check: if node_count reaches MAX_NODES after this evaluation and the next state is not DONE, go to DONE with aborted <= 1. A leaf recorded in that same cycle is still kept.
- BACK (level L, no evaluation, no count):
  - if S_L < 7: S_L += 1, go to EVAL;
  - else if L=3: go to DONE;
  - else lvl <= L+1, stay in BACK.
- DONE:
  - done=1 for exactly one cycle; busy=0; next state IDLE.
  - best_*, found, aborted and node_count are held until the next start.
- S_i below the current level are don't-care to the calculator. They retain their values.
- Async reset mid-search returns to reset values immediately. No done pulse is produced.
- start during EVAL, BACK or DONE is ignored.

Test Plan:
- init_radius=0, cost stub constant 5. start → 8 EVAL at lvl 3 (S_3=0..7), then done. Required: node_count=8, found=0, aborted=0, done exactly 8 cycles after EVAL entry.
- init_radius=0xFFFFFFFF, cost stub constant 5 → path 3/0→2/0→1/0→0/0 accepted, radius=5, then 28 siblings rejected, 3 BACK cycles. Required: node_count=32, best_S all 0, best_cost=5, found=1.
- Cost stub: 0 at levels 3..1; at level 0, 100-10*S_0. init_radius=1000, MAX_NODES=20. Required: leaves S_0=0..7 accepted in turn, then abort at 20. Results: best_S_0=7, best_S_1..3=0, best_cost=30, aborted=1, node_count=20.
- Real metric_calc with noiseless R/InData built from symbols {S3=5,S2=2,S1=7,S0=1}, init_radius large. Required: best_S={1,7,2,5}, best_cost=0, found=1.
- start pulsed while busy: no restart, counts unchanged. rst_n low mid-EVAL: all outputs to reset values asynchronously and no done pulse. After release, a fresh start runs normally.

Source files
------------

// File: rtl/sd_search_ctrl_if.sv
// rtl/sd_search_ctrl_if.sv - host/metric-calculator bundle for the sphere-decoder search controller
interface sd_search_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 13
);
    logic             start;
    logic [WIDTH-1:0] init_radius;
    logic [WIDTH-1:0] current_node_cost;
    logic [2:0]       S_0, S_1, S_2, S_3;
    logic [1:0]       current_node_lvl;
    logic             busy;
    logic             done;
    logic             found;
    logic             aborted;
    logic [2:0]       best_S_0, best_S_1, best_S_2, best_S_3;
    logic [WIDTH-1:0] best_cost;
    logic [CNT_W-1:0] node_count;

    // master is the search controller; slave is the host plus metric calculator
    modport master (
        input  start, init_radius, current_node_cost,
        output S_0, S_1, S_2, S_3, current_node_lvl, busy, done, found, aborted,
               best_S_0, best_S_1, best_S_2, best_S_3, best_cost, node_count
    );
    modport slave (
        output start, init_radius, current_node_cost,
        input  S_0, S_1, S_2, S_3, current_node_lvl, busy, done, found, aborted,
               best_S_0, best_S_1, best_S_2, best_S_3, best_cost, node_count
    );
endinterface

// File: rtl/sd_search_ctrl.sv
// rtl/sd_search_ctrl.sv - depth-first 4-layer 8-ary sphere-decoder tree search with radius shrinking
module sd_search_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MAX_NODES = 4680,
    parameter int CNT_W     = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_search_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, EVAL, BACK, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NODES);

    state_t           state_q;
    logic [2:0]       s_q [4];
    logic [2:0]       best_s_q [4];
    logic [1:0]       lvl_q;
    logic [WIDTH-1:0] radius_q;
    logic [WIDTH-1:0] best_cost_q;
    logic [CNT_W-1:0] node_count_q;
    logic             busy_q, done_q, found_q, aborted_q;

    logic             accept, descend, sib_more, at_root, budget_hit;
    logic             eval_natural_done, eval_to_done, eval_to_back;
    logic [2:0]       cur_s;
    logic [CNT_W-1:0] cnt_inc;

    assign accept     = bus.current_node_cost < radius_q;
    assign descend    = accept && (lvl_q != 2'd0);
    assign cur_s      = s_q[lvl_q];
    assign sib_more   = cur_s != 3'd7;
    assign at_root    = lvl_q == 2'd3;
    assign cnt_inc    = node_count_q + 1'b1;
    assign budget_hit = cnt_inc == MAX_CNT;

    // A leaf recorded in the budget-exhausting cycle is still kept; only the exit path changes.
    assign eval_natural_done = !descend && !sib_more && at_root;
    assign eval_to_done      = eval_natural_done || budget_hit;
    assign eval_to_back      = !descend && !sib_more && !at_root && !budget_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lvl_q        <= 2'd3;
            radius_q     <= '0;
            best_cost_q  <= '0;
            node_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            aborted_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_q[i]      <= 3'd0;
                best_s_q[i] <= 3'd0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        radius_q     <= bus.init_radius;
                        lvl_q        <= 2'd3;
                        node_count_q <= '0;
                        found_q      <= 1'b0;
                        aborted_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= EVAL;
                        for (int i = 0; i < 4; i++) s_q[i] <= 3'd0;
                    end
                end
                EVAL: begin
                    node_count_q <= cnt_inc;
                    if (descend) begin
                        lvl_q             <= lvl_q - 2'd1;
                        s_q[lvl_q - 2'd1] <= 3'd0;
                    end else begin
                        if (accept) begin
                            for (int i = 0; i < 4; i++) best_s_q[i] <= s_q[i];
                            best_cost_q <= bus.current_node_cost;
                            radius_q    <= bus.current_node_cost;
                            found_q     <= 1'b1;
                        end
                        if (sib_more)      s_q[lvl_q] <= cur_s + 3'd1;
                        else if (!at_root) lvl_q      <= lvl_q + 2'd1;
                    end
                    if (eval_to_done) begin
                        aborted_q <= !eval_natural_done;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (eval_to_back) begin
                        state_q <= BACK;
                    end else begin
                        state_q <= EVAL;
                    end
                end
                BACK: begin
                    if (sib_more) begin
                        s_q[lvl_q] <= cur_s + 3'd1;
                        state_q    <= EVAL;
                    end else if (at_root) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        lvl_q <= lvl_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.S_0              = s_q[0];
    assign bus.S_1              = s_q[1];
    assign bus.S_2              = s_q[2];
    assign bus.S_3              = s_q[3];
    assign bus.current_node_lvl = lvl_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.found            = found_q;
    assign bus.aborted          = aborted_q;
    assign bus.best_S_0         = best_s_q[0];
    assign bus.best_S_1         = best_s_q[1];
    assign bus.best_S_2         = best_s_q[2];
    assign bus.best_S_3         = best_s_q[3];
    assign bus.best_cost        = best_cost_q;
    assign bus.node_count       = node_count_q;
endmodule
